// File: rtl/cc_resp_arbiter_if.sv
// Line-response bus of cc_resp_arbiter: hit/fill sources, serializer FIFO write
// port and the monitored R channel of the serializer.
interface cc_resp_arbiter_if;
  localparam int unsigned OFF_W  = 6;
  localparam int unsigned LINE_W = 512;
  localparam int unsigned PKT_W  = OFF_W + LINE_W;

  logic              hit_valid_i;
  logic              hit_ready_o;
  logic [OFF_W-1:0]  hit_offset_i;
  logic [LINE_W-1:0] hit_data_i;
  logic              fill_valid_i;
  logic              fill_ready_o;
  logic [OFF_W-1:0]  fill_offset_i;
  logic [LINE_W-1:0] fill_data_i;
  logic              fifo_full_i;
  logic              fifo_afull_i;
  logic              fifo_wren_o;
  logic [PKT_W-1:0]  fifo_wdata_o;
  logic              rvalid_i;
  logic              rready_i;
  logic              rlast_i;

  // Arbiter side
  modport slave (
    input  hit_valid_i, hit_offset_i, hit_data_i,
    input  fill_valid_i, fill_offset_i, fill_data_i,
    input  fifo_full_i, fifo_afull_i,
    input  rvalid_i, rready_i, rlast_i,
    output hit_ready_o, fill_ready_o, fifo_wren_o, fifo_wdata_o
  );

  // Environment side (sources, FIFO and serializer)
  modport master (
    output hit_valid_i, hit_offset_i, hit_data_i,
    output fill_valid_i, fill_offset_i, fill_data_i,
    output fifo_full_i, fifo_afull_i,
    output rvalid_i, rready_i, rlast_i,
    input  hit_ready_o, fill_ready_o, fifo_wren_o, fifo_wdata_o
  );
endinterface

// File: rtl/cc_resp_arbiter.sv
// Hit/fill read-response arbiter feeding the serializer FIFO with starvation
// protection and an in-flight line limit. Optional per-source grant counters
// are built when CC_RESP_ARB_STAT_EN is defined.
module cc_resp_arbiter #(
  parameter int unsigned STARVE_LIMIT    = 4,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  cc_resp_arbiter_if.slave        bus,
  output logic [3:0]              outstanding_o,
  output logic                    busy_o
`ifdef CC_RESP_ARB_STAT_EN
  ,
  output logic [31:0]             hit_cnt_o,
  output logic [31:0]             fill_cnt_o
`endif
);

  localparam int unsigned OFF_W   = 6;
  localparam int unsigned LINE_W  = 512;
  localparam int unsigned PKT_W   = OFF_W + LINE_W;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned SUM_W   = CNT_W + 1;

  typedef enum logic [0:0] {
    ST_NORMAL    = 1'b0,
    ST_HIT_BOOST = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   starve_q, starve_d;
  logic [CNT_W-1:0]   out_q, out_d;
  logic               wren_q, wren_d;
  logic [PKT_W-1:0]   wdata_q, wdata_d;
  logic               busy_q, busy_d;

  logic               can_push;
  logic               hit_gnt;
  logic               fill_gnt;
  logic               rlast_dec;

  // A write already registered this cycle consumes the last FIFO slot or credit.
  always_comb begin
    can_push = !bus.fifo_full_i
            && !(bus.fifo_afull_i && wren_q)
            && ((SUM_W'(out_q) + SUM_W'(wren_q)) < SUM_W'(MAX_OUTSTANDING));
  end

  // Grant selection, starvation tracking and next-state datapath.
  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    hit_gnt   = 1'b0;
    fill_gnt  = 1'b0;
    wren_d    = 1'b0;
    wdata_d   = wdata_q;
    out_d     = out_q;
    busy_d    = 1'b0;
    rlast_dec = bus.rvalid_i && bus.rready_i && bus.rlast_i && (out_q != '0);

    if (!rst && can_push) begin
      if (state_q == ST_HIT_BOOST) begin
        hit_gnt  = bus.hit_valid_i;
        fill_gnt = bus.fill_valid_i && !bus.hit_valid_i;
      end else begin
        fill_gnt = bus.fill_valid_i;
        hit_gnt  = bus.hit_valid_i && !bus.fill_valid_i;
      end
    end

    case (state_q)
      ST_NORMAL: begin
        if (!bus.hit_valid_i || hit_gnt) begin
          starve_d = '0;
        end else if (fill_gnt) begin
          starve_d = starve_q + CNT_W'(1);
          if (starve_d == CNT_W'(STARVE_LIMIT)) begin
            state_d = ST_HIT_BOOST;
          end
        end
      end
      ST_HIT_BOOST: begin
        if (!bus.hit_valid_i || hit_gnt) begin
          state_d  = ST_NORMAL;
          starve_d = '0;
        end
      end
      default: begin
        state_d  = ST_NORMAL;
        starve_d = '0;
      end
    endcase

    wren_d = hit_gnt || fill_gnt;
    if (hit_gnt) begin
      wdata_d = {bus.hit_offset_i, bus.hit_data_i};
    end else if (fill_gnt) begin
      wdata_d = {bus.fill_offset_i, bus.fill_data_i};
    end

    // A push and a completed burst in the same cycle cancel out.
    if (wren_q && !rlast_dec) begin
      out_d = out_q + CNT_W'(1);
    end else if (!wren_q && rlast_dec) begin
      out_d = out_q - CNT_W'(1);
    end

    busy_d = (out_d != '0) || wren_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_NORMAL;
      starve_q <= '0;
      out_q    <= '0;
      wren_q   <= 1'b0;
      wdata_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      out_q    <= out_d;
      wren_q   <= wren_d;
      wdata_q  <= wdata_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.hit_ready_o  = hit_gnt;
  assign bus.fill_ready_o = fill_gnt;
  assign bus.fifo_wren_o  = wren_q;
  assign bus.fifo_wdata_o = wdata_q;
  assign outstanding_o    = out_q;
  assign busy_o           = busy_q;

`ifdef CC_RESP_ARB_STAT_EN
  logic [31:0] hit_cnt_q, fill_cnt_q;

  // Free-running grant counters, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      fill_cnt_q <= '0;
    end else begin
      if (hit_gnt) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (fill_gnt) begin
        fill_cnt_q <= fill_cnt_q + 32'd1;
      end
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign fill_cnt_o = fill_cnt_q;
`endif

endmodule

// File: tb/tb_cc_resp_arbiter.sv
// Directed self-checking bench for cc_resp_arbiter with a packet scoreboard.
module tb_cc_resp_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  outstanding;
  logic        busy;
`ifdef CC_RESP_ARB_STAT_EN
  logic [31:0] hit_cnt;
  logic [31:0] fill_cnt;
`endif

  cc_resp_arbiter_if bus ();

  cc_resp_arbiter #(
    .STARVE_LIMIT    (4),
    .MAX_OUTSTANDING (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus.slave),
    .outstanding_o (outstanding),
    .busy_o        (busy)
`ifdef CC_RESP_ARB_STAT_EN
    ,
    .hit_cnt_o     (hit_cnt),
    .fill_cnt_o    (fill_cnt)
`endif
  );

  always #5 clk = ~clk;

  int unsigned      vectors = 0;
  int unsigned      miscompares = 0;
  int unsigned      exp_hits = 0;
  int unsigned      exp_fills = 0;
  logic [517:0]     exp_q [$];

  task automatic chk(input string tag, input logic [517:0] obs, input logic [517:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] rand_line();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Every FIFO write is checked against the oldest expected packet.
  always @(posedge clk) begin
    #1;
    if (bus.fifo_wren_o === 1'b1) begin
      if (exp_q.size() == 0) chk("sb_unexpected_push", 518'(bus.fifo_wren_o), 518'(0));
      else                   chk("sb_push_data", bus.fifo_wdata_o, exp_q.pop_front());
    end
  end

  // One clock: drive at negedge, check readies, return 1 time unit after posedge.
  task automatic step(input logic hv, input logic fv, input logic [5:0] hoff,
                      input logic [5:0] foff, input logic full, input logic afull,
                      input logic rl, input logic exp_hr, input logic exp_fr,
                      input string tag);
    logic [511:0] hd;
    logic [511:0] fd;
    @(negedge clk);
    hd = rand_line();
    fd = rand_line();
    bus.hit_valid_i   = hv;
    bus.hit_offset_i  = hoff;
    bus.hit_data_i    = hd;
    bus.fill_valid_i  = fv;
    bus.fill_offset_i = foff;
    bus.fill_data_i   = fd;
    bus.fifo_full_i   = full;
    bus.fifo_afull_i  = afull;
    bus.rvalid_i      = rl;
    bus.rready_i      = rl;
    bus.rlast_i       = rl;
    #1;
    chk({tag, "_hit_ready"},  518'(bus.hit_ready_o),  518'(exp_hr));
    chk({tag, "_fill_ready"}, 518'(bus.fill_ready_o), 518'(exp_fr));
    if (exp_hr) begin exp_q.push_back({hoff, hd}); exp_hits++;  end
    if (exp_fr) begin exp_q.push_back({foff, fd}); exp_fills++; end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rl);
    step(1'b0, 1'b0, 6'h0, 6'h0, 1'b0, 1'b0, rl, 1'b0, 1'b0, "idle");
  endtask

  task automatic chk_regs(input string tag, input logic wren, input logic [3:0] outs,
                          input logic bsy);
    chk({tag, "_wren"},        518'(bus.fifo_wren_o), 518'(wren));
    chk({tag, "_outstanding"}, 518'(outstanding),     518'(outs));
    chk({tag, "_busy"},        518'(busy),            518'(bsy));
  endtask

  initial begin
    logic hit_win;
    rst = 1'b1;
    bus.hit_valid_i = 1'b0;  bus.hit_offset_i = '0;  bus.hit_data_i = '0;
    bus.fill_valid_i = 1'b0; bus.fill_offset_i = '0; bus.fill_data_i = '0;
    bus.fifo_full_i = 1'b0;  bus.fifo_afull_i = 1'b0;
    bus.rvalid_i = 1'b0;     bus.rready_i = 1'b0;    bus.rlast_i = 1'b0;

    // Reset: readies held low even with both sources valid
    step(1'b1, 1'b1, 6'h1, 6'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "in_reset0");
    step(1'b1, 1'b1, 6'h1, 6'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "in_reset1");
    rst = 1'b0;
    chk_regs("reset", 1'b0, 4'd0, 1'b0);
    chk("reset_wdata", bus.fifo_wdata_o, 518'(0));

    // Single hit, offset 0x10
    step(1'b1, 1'b0, 6'h10, 6'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "t1_hit");
    chk_regs("t1_push", 1'b1, 4'd0, 1'b1);
    chk("t1_offset", 518'(bus.fifo_wdata_o[517:512]), 518'(6'h10));
    idle(1'b0);
    chk_regs("t1_inflight", 1'b0, 4'd1, 1'b1);
    idle(1'b1);
    chk_regs("t1_drained", 1'b0, 4'd0, 1'b0);

    // Both valid: F,F,F,F,H repeating
    for (int i = 0; i < 10; i++) begin
      hit_win = ((i % 5) == 4);
      step(1'b1, 1'b1, 6'($urandom), 6'($urandom), 1'b0, 1'b0, 1'b1,
           hit_win, !hit_win, "t2_starve");
    end
    idle(1'b1);
    idle(1'b1);
    chk_regs("t2_drained", 1'b0, 4'd0, 1'b0);

    // Almost-full with a pending write, then full
    step(1'b0, 1'b1, 6'h0, 6'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "t3_fill");
    step(1'b0, 1'b1, 6'h0, 6'($urandom), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "t3_afull_pending");
    step(1'b0, 1'b1, 6'h0, 6'($urandom), 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "t3_afull_free");
    step(1'b1, 1'b0, 6'($urandom), 6'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "t3_full0");
    step(1'b1, 1'b0, 6'($urandom), 6'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "t3_full1");
    chk_regs("t3_full", 1'b0, 4'd2, 1'b1);
    step(1'b1, 1'b0, 6'($urandom), 6'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "t3_unfull");
    idle(1'b1);
    idle(1'b1);
    chk_regs("t3_drained", 1'b0, 4'd0, 1'b0);

    // Outstanding limit
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b1, 6'h0, 6'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "t4_fill");
    step(1'b0, 1'b1, 6'h0, 6'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "t4_stall");
    chk_regs("t4_limit", 1'b0, 4'd4, 1'b1);
    step(1'b0, 1'b1, 6'h0, 6'($urandom), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "t4_stall_rlast");
    step(1'b0, 1'b1, 6'h0, 6'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "t4_fifth");
    idle(1'b1);
    chk_regs("t4_push_and_rlast", 1'b0, 4'd3, 1'b1);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    chk_regs("t4_drained", 1'b0, 4'd0, 1'b0);

    // Reset after boost entry with a write pending
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b1, 6'($urandom), 6'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "t5_fill");
    rst = 1'b1;
    step(1'b1, 1'b1, 6'($urandom), 6'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "t5_in_reset");
    rst = 1'b0;
    exp_hits  = 0;
    exp_fills = 0;
    chk_regs("t5_after_reset", 1'b0, 4'd0, 1'b0);
    step(1'b1, 1'b1, 6'($urandom), 6'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "t5_normal");
    idle(1'b0);
    idle(1'b1);
    chk_regs("t5_drained", 1'b0, 4'd0, 1'b0);

    // Grant counting: 3 hits then 5 fills after a fresh reset
    rst = 1'b1;
    idle(1'b0);
    rst = 1'b0;
    exp_hits  = 0;
    exp_fills = 0;
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0, 6'($urandom), 6'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "t6_hit");
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b1, 6'h0, 6'($urandom), 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "t6_fill");
    idle(1'b1);
    idle(1'b1);
    chk_regs("t6_drained", 1'b0, 4'd0, 1'b0);
`ifdef CC_RESP_ARB_STAT_EN
    chk("t6_hit_cnt",  518'(hit_cnt),  518'(exp_hits));
    chk("t6_fill_cnt", 518'(fill_cnt), 518'(exp_fills));
`endif

    chk("sb_leftover", 518'(exp_q.size()), 518'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
